hilo_muldiv_ctrl: RTL and testbench
===================================

HILO_MULDIV_CTRL -- requirements
Module: hilo_muldiv_ctrl

Interface
REQ-001 SHALL have: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have: start  input  1  one-cycle request to begin an operation, sampled on clk.
REQ-004 SHALL have: op_sel  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; valid with start.
REQ-005 SHALL have: op_a, op_b  input  32 each  rs/rt operands; dividend=op_a, divisor=op_b; valid with start.
REQ-006 SHALL have: mthi, mtlo  input  1 each  write wdata into HI/LO.
REQ-007 SHALL have: wdata  input  32  source data for mthi/mtlo.
REQ-008 SHALL have: mfhi, mflo  input  1 each  read request from decode.
REQ-009 SHALL have: flush  input  1  abort any in-flight operation.
REQ-010 SHALL have: hi, lo  output  32 each  architectural HI/LO registers.
REQ-011 SHALL have: hilo_rd  output  32  combinational mfhi/mflo read data.
REQ-012 SHALL have: busy  output  1  operation in flight.
REQ-013 SHALL have: stall  output  1  combinational; freezes decode.
REQ-014 SHALL have: done  output  1  one-cycle pulse marking the HI/LO result commit.

Function
REQ-015 SHALL implement FSM states IDLE, MUL, DIV, FIX; the state is held in registers.
REQ-016 In IDLE, start SHALL latch operands and op_sel and enter MUL (op_sel 0x) or DIV (op_sel 1x); busy=1 from the following cycle.
REQ-017 MUL SHALL last 4 cycles counted from the start edge E0; the 64-bit product SHALL be written to HI[63:32]/LO[31:0] at edge E4, then the FSM SHALL return to IDLE.
REQ-018 MULT SHALL treat operands as two's-complement; MULTU SHALL treat them as unsigned; the full 64-bit result SHALL be kept with no truncation.
REQ-019 DIV SHALL run a restoring divider on operand magnitudes, one quotient bit per cycle, for 32 cycles (E1..E32); FIX SHALL apply signs; LO=quotient and HI=remainder SHALL be written at E33.
REQ-020 For signed divide, the quotient sign SHALL be sign(a) XOR sign(b) and the remainder sign SHALL equal sign(a) (truncating division).
REQ-021 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give LO=0x80000000 and HI=0x00000000.
REQ-022 A divisor of zero SHALL give LO=0xFFFFFFFF and HI=op_a, with the same 33-cycle latency.
REQ-023 done SHALL be high for exactly the one cycle following the commit edge; busy SHALL be low in that cycle.
REQ-024 While busy=1, stall SHALL equal start|mfhi|mflo|mthi|mtlo; when busy=0, stall SHALL be 0.
REQ-025 start while busy SHALL be ignored; the requester holds it under stall.
REQ-026 In IDLE, mthi/mtlo SHALL write wdata at the next edge; mthi and mtlo together SHALL write both registers.
REQ-027 start together with mthi/mtlo in IDLE: start SHALL win and the mthi/mtlo write SHALL be discarded.
REQ-028 hilo_rd SHALL be hi when mfhi=1, else lo when mflo=1, else 0; mfhi has priority when both are asserted.
REQ-029 flush during MUL/DIV/FIX SHALL return the FSM to IDLE at the next edge with HI/LO unchanged and no done pulse; flush in IDLE SHALL have no effect.
REQ-030 flush together with start in IDLE SHALL suppress the start.

Reset
REQ-031 rst=1 SHALL immediately force: state IDLE; hi=0, lo=0; busy=0; done=0; counter=0; latched operands=0.
REQ-032 Reset asserted mid-operation SHALL discard the operation; after release, the block SHALL accept start on the first edge.

Verification
REQ-033 MULT 0xFFFFFFFE x 0x00000003 -> at E4 HI=0xFFFFFFFF, LO=0xFFFFFFFA; done for 1 cycle; busy for 4 cycles.
REQ-034 MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-035 DIV -7 / 2 -> at E33 LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7 / 0 -> LO=0xFFFFFFFF, HI=0x00000007.
REQ-036 mflo held from E1 of a DIV -> stall=1 through the cycle before done; hilo_rd=new LO in the done cycle with stall=0.
REQ-037 mthi 0x12345678 in IDLE, then a flush at E10 of a DIV -> HI stays 0x12345678, no done, busy=0 after E11.
REQ-038 rst pulse at E5 of a DIV -> HI=LO=0 and busy=0 immediately; start at the next edge begins a fresh operation.

Source files
------------

// File: rtl/hilo_muldiv_ctrl_if.sv
// hilo_muldiv_ctrl_if
// Groups the request and result signals of the HI/LO multiply/divide unit.
//   slave  : the unit itself (takes requests, drives HI/LO, read data, status)
//   master : the requester (decode/execute side)
// Signals:
//   start, op_sel[1:0], op_a[31:0], op_b[31:0] : operation request
//   mthi, mtlo, wdata[31:0]                    : direct HI/LO writes
//   mfhi, mflo                                 : read requests
//   flush                                      : abort in-flight operation
//   hi, lo, hilo_rd                            : architectural registers, read data
//   busy, stall, done                          : status
interface hilo_muldiv_ctrl_if;
  logic        start;
  logic [1:0]  op_sel;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        mfhi;
  logic        mflo;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] hilo_rd;
  logic        busy;
  logic        stall;
  logic        done;

  modport slave (
    input  start, op_sel, op_a, op_b, mthi, mtlo, wdata, mfhi, mflo, flush,
    output hi, lo, hilo_rd, busy, stall, done
  );

  modport master (
    output start, op_sel, op_a, op_b, mthi, mtlo, wdata, mfhi, mflo, flush,
    input  hi, lo, hilo_rd, busy, stall, done
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl
// HI/LO register file with a multi-cycle multiplier (4 cycles) and a
// restoring divider (32 iteration cycles plus a sign-fix cycle).
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : hilo_muldiv_ctrl_if.slave (request, HI/LO access, status)
module hilo_muldiv_ctrl (
  input  logic                 clk,
  input  logic                 rst,
  hilo_muldiv_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] a_q, b_q;
  logic        sgn_q;
  logic [31:0] rem_q, quo_q, dvs_q;
  logic [31:0] hi_q, lo_q;
  logic        done_q;

  logic        accept, mul_commit, div_step, fix_commit;

  // Request-side magnitudes, taken at the start edge
  logic        in_sgn;
  logic [31:0] mag_a, mag_b;
  assign in_sgn = ~bus.op_sel[0];
  assign mag_a  = (in_sgn && bus.op_a[31]) ? (32'd0 - bus.op_a) : bus.op_a;
  assign mag_b  = (in_sgn && bus.op_b[31]) ? (32'd0 - bus.op_b) : bus.op_b;

  // Multiplier: sign/zero extension to 64 bits makes a 64-bit truncated
  // product exact for both signed and unsigned operands
  logic [63:0] ext_a, ext_b, prod;
  assign ext_a = sgn_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign ext_b = sgn_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign prod  = ext_a * ext_b;

  // Restoring divider step; the partial remainder is always below the
  // divisor, so the subtraction only needs the low 32 bits
  logic [32:0] r_sh;
  logic        q_bit;
  logic [31:0] r_sub, rem_nxt;
  assign r_sh    = {rem_q, quo_q[31]};
  assign q_bit   = (r_sh >= {1'b0, dvs_q});
  assign r_sub   = r_sh[31:0] - dvs_q;
  assign rem_nxt = q_bit ? r_sub : r_sh[31:0];

  // Sign fix-up; a zero divisor bypasses it entirely
  logic        neg_q, neg_r;
  logic [31:0] q_fix, r_fix;
  assign neg_q = sgn_q & (a_q[31] ^ b_q[31]);
  assign neg_r = sgn_q & a_q[31];
  assign q_fix = (b_q == '0) ? '1  : (neg_q ? (32'd0 - quo_q) : quo_q);
  assign r_fix = (b_q == '0) ? a_q : (neg_r ? (32'd0 - rem_q) : rem_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    mul_commit = 1'b0;
    div_step   = 1'b0;
    fix_commit = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          accept    = 1'b1;
          state_nxt = bus.op_sel[1] ? DIV : MUL;
        end
      end
      MUL: begin
        if (bus.flush) state_nxt = IDLE;
        else if (cnt == 5'd3) begin
          mul_commit = 1'b1;
          state_nxt  = IDLE;
        end
      end
      DIV: begin
        if (bus.flush) state_nxt = IDLE;
        else begin
          div_step = 1'b1;
          if (cnt == 5'd31) state_nxt = FIX;
        end
      end
      FIX: begin
        state_nxt = IDLE;
        if (!bus.flush) fix_commit = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sgn_q  <= 1'b0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= mul_commit | fix_commit;

      // Counter restarts on every state change, counts within MUL/DIV
      if (state_nxt != state)                 cnt <= '0;
      else if (state == MUL || state == DIV)  cnt <= cnt + 5'd1;

      if (accept) begin
        a_q   <= bus.op_a;
        b_q   <= bus.op_b;
        sgn_q <= in_sgn;
        quo_q <= mag_a;
        dvs_q <= mag_b;
        rem_q <= '0;
      end else if (div_step) begin
        rem_q <= rem_nxt;
        quo_q <= {quo_q[30:0], q_bit};
      end

      if (mul_commit) begin
        hi_q <= prod[63:32];
        lo_q <= prod[31:0];
      end else if (fix_commit) begin
        hi_q <= r_fix;
        lo_q <= q_fix;
      end else if (state == IDLE && !accept) begin
        if (bus.mthi) hi_q <= bus.wdata;
        if (bus.mtlo) lo_q <= bus.wdata;
      end
    end
  end

  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.done    = done_q;
  assign bus.busy    = (state != IDLE);
  assign bus.stall   = bus.busy & (bus.start | bus.mfhi | bus.mflo | bus.mthi | bus.mtlo);
  assign bus.hilo_rd = bus.mfhi ? hi_q : (bus.mflo ? lo_q : '0);

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Testbench for hilo_muldiv_ctrl: an arithmetic reference model (result
// computed at the start edge, released after a fixed latency) checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_hilo_muldiv_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hilo_muldiv_ctrl_if bus ();

  hilo_muldiv_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [31:0] p_hi, p_lo;
  logic        m_done = 1'b0;
  int          m_rem = 0;

  function automatic logic [63:0] ref_result(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: begin q = sa * sb; res = q; end
      2'd1: res = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi = '0; m_lo = '0; m_done = 1'b0; m_rem = 0;
    end else begin
      m_done = 1'b0;
      if (m_rem != 0) begin
        if (bus.flush) m_rem = 0;
        else begin
          m_rem--;
          if (m_rem == 0) begin
            m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
          end
        end
      end else if (bus.start && !bus.flush) begin
        {p_hi, p_lo} = ref_result(bus.op_sel, bus.op_a, bus.op_b);
        m_rem = bus.op_sel[1] ? 33 : 4;
      end else begin
        if (bus.mthi) m_hi = bus.wdata;
        if (bus.mtlo) m_lo = bus.wdata;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic        e_busy;
    logic [31:0] e_rd;
    e_busy = (m_rem != 0);
    e_rd   = bus.mfhi ? m_hi : (bus.mflo ? m_lo : 32'd0);
    chk("hi", bus.hi, m_hi);
    chk("lo", bus.lo, m_lo);
    chk("busy", {31'd0, bus.busy}, {31'd0, e_busy});
    chk("done", {31'd0, bus.done}, {31'd0, m_done});
    chk("stall", {31'd0, bus.stall},
        {31'd0, e_busy & (bus.start | bus.mfhi | bus.mflo | bus.mthi | bus.mtlo)});
    chk("hilo_rd", bus.hilo_rd, e_rd);
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.op_sel = op; bus.op_a = a; bus.op_b = b;
    cyc();
    bus.start = 1'b0;
  endtask

  // Waits (bounded) for done; the number of edges waited is the latency check
  task automatic wait_done(input string name, input int exp_lat);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 60) begin
      cyc();
      n++;
    end
    chk(name, n, exp_lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 0; bus.op_sel = 0; bus.op_a = 0; bus.op_b = 0;
    bus.mthi = 0; bus.mtlo = 0; bus.wdata = 0;
    bus.mfhi = 0; bus.mflo = 0; bus.flush = 0;
    #2 rst = 1'b1;
    #1;
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // MULT / MULTU
    issue(2'd0, 32'hFFFFFFFE, 32'h00000003);
    wait_done("mult_lat", 4);
    chk("mult_hi", bus.hi, 32'hFFFFFFFF);
    chk("mult_lo", bus.lo, 32'hFFFFFFFA);
    cyc();
    issue(2'd1, 32'hFFFFFFFE, 32'h00000003);
    wait_done("multu_lat", 4);
    chk("multu_hi", bus.hi, 32'h00000002);
    chk("multu_lo", bus.lo, 32'hFFFFFFFA);
    cyc();

    // DIV / DIVU including zero divisor and overflow
    issue(2'd2, 32'hFFFFFFF9, 32'd2);
    wait_done("div_lat", 33);
    chk("div_lo", bus.lo, 32'hFFFFFFFD);
    chk("div_hi", bus.hi, 32'hFFFFFFFF);
    cyc();
    issue(2'd3, 32'd7, 32'd0);
    wait_done("divu0_lat", 33);
    chk("divu0_lo", bus.lo, 32'hFFFFFFFF);
    chk("divu0_hi", bus.hi, 32'h00000007);
    cyc();
    issue(2'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_done("ovf_lat", 33);
    chk("ovf_lo", bus.lo, 32'h80000000);
    chk("ovf_hi", bus.hi, 32'h00000000);
    cyc();
    issue(2'd2, 32'hFFFFFFF9, 32'd0);
    wait_done("div0_lat", 33);
    chk("div0_lo", bus.lo, 32'hFFFFFFFF);
    chk("div0_hi", bus.hi, 32'hFFFFFFF9);
    cyc();

    // mflo held through a DIV: stalled until the done cycle
    issue(2'd2, 32'd100, 32'd7);
    bus.mflo = 1'b1;
    wait_done("mflo_lat", 33);
    chk("mflo_rd", bus.hilo_rd, 32'd14);
    chk("mflo_stall", {31'd0, bus.stall}, 32'd0);
    bus.mflo = 1'b0;
    cyc();

    // mthi then flush mid-DIV
    bus.mthi = 1'b1; bus.wdata = 32'h12345678;
    cyc();
    bus.mthi = 1'b0;
    chk("mthi_hi", bus.hi, 32'h12345678);
    issue(2'd3, 32'd1000, 32'd3);
    repeat (10) cyc();
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    chk("flush_busy", {31'd0, bus.busy}, 32'd0);
    chk("flush_hi", bus.hi, 32'h12345678);
    repeat (40) cyc();

    // mthi+mtlo together, then read priority
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'hA5A5A5A5;
    cyc();
    bus.mthi = 1'b0; bus.wdata = 32'h22222222;
    cyc();
    bus.mtlo = 1'b0;
    bus.mfhi = 1'b1; bus.mflo = 1'b1;
    #1 chk("rd_prio", bus.hilo_rd, 32'hA5A5A5A5);
    bus.mfhi = 1'b0;
    #1 chk("rd_lo", bus.hilo_rd, 32'h22222222);
    bus.mflo = 1'b0;
    cyc();

    // start wins over mthi in IDLE
    bus.mthi = 1'b1; bus.wdata = 32'hDEADBEEF;
    issue(2'd1, 32'd2, 32'd3);
    bus.mthi = 1'b0;
    wait_done("startwin_lat", 4);
    chk("startwin_hi", bus.hi, 32'h0);
    chk("startwin_lo", bus.lo, 32'd6);
    cyc();

    // start while busy is ignored
    issue(2'd0, 32'd5, 32'd6);
    bus.start = 1'b1; bus.op_sel = 2'd2; bus.op_a = 32'd9; bus.op_b = 32'd4;
    cyc(); cyc();
    bus.start = 1'b0;
    wait_done("ignore_lat", 2);
    chk("ignore_lo", bus.lo, 32'd30);
    cyc();
    chk("ignore_idle", {31'd0, bus.busy}, 32'd0);

    // flush with start in IDLE suppresses it
    bus.start = 1'b1; bus.flush = 1'b1;
    cyc();
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("fstart_busy", {31'd0, bus.busy}, 32'd0);

    // reset mid-DIV, then immediate restart
    bus.mthi = 1'b1; bus.wdata = 32'h00000077;
    cyc();
    bus.mthi = 1'b0;
    issue(2'd2, 32'd100, 32'd7);
    repeat (5) cyc();
    rst = 1'b1;
    #1;
    chk("mrst_hi", bus.hi, 32'h0);
    chk("mrst_lo", bus.lo, 32'h0);
    chk("mrst_busy", {31'd0, bus.busy}, 32'd0);
    #1;
    rst = 1'b0;
    bus.start = 1'b1; bus.op_sel = 2'd0; bus.op_a = 32'd3; bus.op_b = 32'd5;
    cyc();
    bus.start = 1'b0;
    chk("restart_busy", {31'd0, bus.busy}, 32'd1);
    wait_done("restart_lat", 4);
    chk("restart_lo", bus.lo, 32'd15);

    repeat (3) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
